// File: rtl/legv8_pkg.sv
// Shared types and constants for the multicycle LEGv8 control unit.
// State encoding, opcode patterns/masks, ALUop and ALUSrcB encodings.
package legv8_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_CBZ    = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] MASK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_B     = 11'b00010100000;
    localparam logic [10:0] MASK_B   = 11'b11111100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    typedef struct packed {
        logic is_r;
        logic is_ld;
        logic is_st;
        logic is_cbz;
        logic is_b;
        logic illegal;
    } op_class_t;

    function automatic logic op_match(
        input logic [10:0] op,
        input logic [10:0] pat,
        input logic [10:0] mask
    );
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier for the LEGv8 control FSM.
// Ports: Opcode (in, 11) -> cls (out, op_class_t: is_r/is_ld/is_st/is_cbz/is_b/illegal).
module mc_opcode_class
    import legv8_pkg::*;
(
    input  logic [10:0] Opcode,
    output op_class_t   cls
);

    logic any_legal;

    assign cls.is_r   = (Opcode == OP_ADD) || (Opcode == OP_SUB) ||
                        (Opcode == OP_AND) || (Opcode == OP_ORR);
    assign cls.is_ld  = (Opcode == OP_LDUR);
    assign cls.is_st  = (Opcode == OP_STUR);
    assign cls.is_cbz = op_match(Opcode, OP_CBZ, MASK_CBZ);
    assign cls.is_b   = op_match(Opcode, OP_B, MASK_B);

    assign any_legal   = cls.is_r | cls.is_ld | cls.is_st | cls.is_cbz | cls.is_b;
    assign cls.illegal = ~any_legal;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle LEGv8 datapath with memory timeout trap.
// Ports: CLK, Reset_L (async low), Opcode, Zero, mem_ready in; datapath controls,
// sticky trap and debug state out. MC_PERF_CNT_EN adds cycle_cnt/retired_cnt.
module multicycle_control
    import legv8_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef MC_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [1:0]  ALUop,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        Reg2Loc,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        trap,
    output logic [3:0]  state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 1);

    state_t        cur, nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          timed_out;
    op_class_t     cls;

    mc_opcode_class u_class (
        .Opcode (Opcode),
        .cls    (cls)
    );

    // Last permitted wait cycle; a ready on this cycle still completes.
    assign timed_out = (tmo_cnt == LAST_WAIT);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            cur     <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            cur     <= nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    always_comb begin
        nxt      = cur;
        tmo_nxt  = '0;
        ALUop    = ALUOP_ADD;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REG;
        Reg2Loc  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        unique case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (timed_out) begin
                    nxt = S_TRAP;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BR;
                Reg2Loc = cls.is_st | cls.is_cbz;
                unique case (1'b1)
                    cls.is_r:               nxt = S_EXEC_R;
                    cls.is_ld | cls.is_st:  nxt = S_ADDR;
                    cls.is_cbz:             nxt = S_CBZ;
                    cls.is_b:               nxt = S_JUMP;
                    default:                nxt = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_RTYPE;
                nxt     = S_WB_R;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                nxt     = cls.is_ld ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready)      nxt = S_WB_LD;
                else if (timed_out) nxt = S_TRAP;
                else                tmo_nxt = tmo_cnt + 1'b1;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                Reg2Loc  = 1'b1;
                if (mem_ready)      nxt = S_FETCH;
                else if (timed_out) nxt = S_TRAP;
                else                tmo_nxt = tmo_cnt + 1'b1;
            end
            S_CBZ: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_PASSB;
                Reg2Loc = 1'b1;
                PCSrc   = 1'b1;
                PCWrite = Zero;
                nxt     = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = 1'b1;
                PCWrite = 1'b1;
                nxt     = S_FETCH;
            end
            S_TRAP: nxt = S_TRAP;
            default: nxt = S_TRAP;
        endcase
    end

    assign trap  = (cur == S_TRAP);
    assign state = cur;

`ifdef MC_PERF_CNT_EN
    logic active, retire;

    assign active = (cur != S_IDLE) && (cur != S_TRAP);
    assign retire = (nxt == S_FETCH) &&
                    ((cur == S_WB_R) || (cur == S_WB_LD) ||
                     (cur == S_MEM_WR) || (cur == S_CBZ) ||
                     (cur == S_JUMP));

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (active) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) retired_cnt <= retired_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle plans
// checked every cycle, plus directed reset, trap and timeout cases.
module tb_multicycle_control;
    import legv8_pkg::*;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [10:0] Opcode = '0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [1:0]  ALUop, ALUSrcB;
    logic        ALUSrcA, Reg2Loc, IorD, MemRead, MemWrite, IRWrite;
    logic        PCWrite, PCSrc, MemtoReg, RegWrite, trap;
    logic [3:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .Zero(Zero),
        .mem_ready(mem_ready), .ALUop(ALUop), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .Reg2Loc(Reg2Loc), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .trap(trap), .state(state)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       reg2loc, iord, mr, mw, irw, pcw, pcsrc, m2r, rw, trp;
    } vec_t;

    typedef enum {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

    vec_t exp_q[$];
    bit   rdy_q[$];
    vec_t act;
    int   errors = 0;
    int   checks = 0;
    int   m_cycles = 0;
    int   m_retired = 0;
    bit   m_trapped = 0;

    assign act = {state, ALUop, ALUSrcA, ALUSrcB, Reg2Loc, IorD, MemRead,
                  MemWrite, IRWrite, PCWrite, PCSrc, MemtoReg, RegWrite, trap};

    function automatic vec_t blank(state_t s);
        vec_t v = '0;
        v.st  = s;
        v.trp = (s == S_TRAP);
        return v;
    endfunction

    function automatic bit legal(logic [10:0] op);
        logic [10:0] o = op;
        return o == 11'b10001011000 || o == 11'b11001011000 ||
               o == 11'b10001010000 || o == 11'b10101010000 ||
               o == 11'b11111000010 || o == 11'b11111000000 ||
               o[10:3] == 8'b10110100 || o[10:5] == 6'b000101;
    endfunction

    function automatic logic [10:0] pick_op(kind_t k);
        logic [10:0] op;
        case (k)
            K_R: case ($urandom % 4)
                0: op = 11'b10001011000;
                1: op = 11'b11001011000;
                2: op = 11'b10001010000;
                default: op = 11'b10101010000;
            endcase
            K_LD:  op = 11'b11111000010;
            K_ST:  op = 11'b11111000000;
            K_CBZ: op = {8'b10110100, 3'($urandom)};
            K_B:   op = {6'b000101, 5'($urandom)};
            default: begin
                op = 11'($urandom);
                while (legal(op)) op = 11'($urandom);
            end
        endcase
        return op;
    endfunction

    function automatic void add(vec_t v, bit r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endfunction

    function automatic void trap_tail(int tail);
        repeat (tail) add(blank(S_TRAP), 1'($urandom));
        m_trapped = 1;
    endfunction

    // Waiting cycles of a memory state; returns 1 when the wait hits the limit.
    function automatic bit waits(vec_t base, int w, int tail);
        int n = (w < TO) ? w : TO;
        repeat (n) add(base, 1'b0);
        if (w >= TO) begin
            trap_tail(tail);
            return 1;
        end
        return 0;
    endfunction

    // Expected per-cycle outputs of one instruction from FETCH onward.
    function automatic void plan(kind_t k, logic z, int wf, int wm, int tail);
        vec_t v;
        m_trapped = 0;
        v = blank(S_FETCH);
        v.mr = 1; v.srcb = 2'b01;
        if (waits(v, wf, tail)) return;
        v.irw = 1; v.pcw = 1;
        add(v, 1'b1);
        v = blank(S_DECODE);
        v.srcb = 2'b11;
        v.reg2loc = (k == K_ST) || (k == K_CBZ);
        add(v, 1'($urandom));
        case (k)
            K_R: begin
                v = blank(S_EXEC_R); v.srca = 1; v.aluop = 2'b10;
                add(v, 1'($urandom));
                v = blank(S_WB_R); v.rw = 1;
                add(v, 1'($urandom));
            end
            K_LD, K_ST: begin
                v = blank(S_ADDR); v.srca = 1; v.srcb = 2'b10;
                add(v, 1'($urandom));
                if (k == K_LD) begin
                    v = blank(S_MEM_RD); v.iord = 1; v.mr = 1;
                end else begin
                    v = blank(S_MEM_WR); v.iord = 1; v.mw = 1; v.reg2loc = 1;
                end
                if (waits(v, wm, tail)) return;
                add(v, 1'b1);
                if (k == K_LD) begin
                    v = blank(S_WB_LD); v.rw = 1; v.m2r = 1;
                    add(v, 1'($urandom));
                end
            end
            K_CBZ: begin
                v = blank(S_CBZ); v.srca = 1; v.aluop = 2'b01;
                v.reg2loc = 1; v.pcsrc = 1; v.pcw = z;
                add(v, 1'($urandom));
            end
            K_B: begin
                v = blank(S_JUMP); v.pcsrc = 1; v.pcw = 1;
                add(v, 1'($urandom));
            end
            default: begin
                trap_tail(tail);
                return;
            end
        endcase
        m_retired++;
    endfunction

    task automatic check_lit(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Entered just after a rising edge; leaves just after a rising edge.
    task automatic drain_n(int n, string tag);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            @(negedge CLK);
            checks++;
            if (act !== v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h", tag, i, act, v);
            end
            if (v.st != S_IDLE && v.st != S_TRAP) m_cycles++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic perf_check(string tag);
`ifdef MC_PERF_CNT_EN
        check_lit({tag, "_cyc"}, int'(cycle_cnt), m_cycles);
        check_lit({tag, "_ret"}, int'(retired_cnt), m_retired);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic do_reset();
        Reset_L = 1'b0;
        mem_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (act !== blank(S_IDLE)) begin
            errors++;
            $display("FAIL reset: got %h want %h", act, blank(S_IDLE));
        end
        m_cycles = 0;
        m_retired = 0;
        @(posedge CLK);
        #1;
        Reset_L = 1'b1;
        add(blank(S_IDLE), 1'b0);
        drain_n(1, "idle");
    endtask

    task automatic do_instr(kind_t k, logic z, int wf, int wm, int tail, string tag);
        Opcode = pick_op(k);
        Zero = z;
        plan(k, z, wf, wm, tail);
        drain_n(exp_q.size(), tag);
        perf_check(tag);
        if (m_trapped) do_reset();
    endtask

    function automatic int rand_wait();
        int r = $urandom % 40;
        if (r < 24) return r % 3;
        if (r < 34) return $urandom % 8;
        if (r < 38) return TO - 1;
        return TO;
    endfunction

    initial begin
        kind_t k;
        @(posedge CLK);
        #1;
        do_reset();

        Opcode = 11'b10001011000;
        plan(K_R, 1'b0, 0, 0, 0);
        check_lit("len_add", exp_q.size(), 4);
        check_lit("add_exec_aluop", int'(exp_q[2].aluop), 2);
        drain_n(exp_q.size(), "add");

        Opcode = 11'b11111000010;
        plan(K_LD, 1'b0, 0, 3, 0);
        check_lit("len_ldur_w3", exp_q.size(), 8);
        drain_n(exp_q.size(), "ldur");

        Opcode = 11'b10110100101;
        Zero = 1'b1;
        plan(K_CBZ, 1'b1, 0, 0, 0);
        check_lit("len_cbz", exp_q.size(), 3);
        check_lit("cbz_taken_pcw", int'(exp_q[2].pcw), 1);
        drain_n(exp_q.size(), "cbz_z1");
        do_instr(K_CBZ, 1'b0, 0, 0, 0, "cbz_z0");

        do_reset();
        do_instr(K_R, 1'b0, 0, 0, 0, "add2");
        do_instr(K_B, 1'b0, 0, 0, 0, "b");
        do_instr(K_ST, 1'b0, 0, 0, 0, "stur");
`ifdef MC_PERF_CNT_EN
        check_lit("retired_3", int'(retired_cnt), 3);
`endif

        Opcode = 11'b11111111111;
        plan(K_ILL, 1'b0, 0, 0, 20);
        check_lit("len_ill", exp_q.size(), 22);
        drain_n(exp_q.size(), "illegal");
        do_reset();

        do_instr(K_R, 1'b0, TO, 0, 4, "fetch_timeout");
        do_instr(K_R, 1'b0, TO - 1, 0, 0, "fetch_ready16");
        do_instr(K_LD, 1'b0, 0, TO, 4, "rd_timeout");
        do_instr(K_ST, 1'b0, 0, TO - 1, 0, "wr_ready16");

        Opcode = 11'b11111000000;
        plan(K_ST, 1'b0, 0, 5, 0);
        drain_n(4, "stur_mid");
        mem_ready = 1'b0;
        #2;
        check_lit("memwrite_pre", int'(MemWrite), 1);
        Reset_L = 1'b0;
        #1;
        check_lit("memwrite_async", int'(MemWrite), 0);
        check_lit("state_async", int'(state), 0);
        exp_q.delete();
        rdy_q.delete();
        do_reset();

        for (int i = 0; i < 150; i++) begin
            k = kind_t'($urandom % 6);
            if (k == K_ILL && ($urandom % 3) != 0) k = K_R;
            do_instr(k, 1'($urandom), rand_wait(), rand_wait(), 3,
                     $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
